ahb_arbiter: RTL and testbench

- Bus arbiter for the AHB interconnect: shares the master side between up to 4 requesters.
- Drives hgrant and hmaster, the latter also feeding the slave interfaces and the address/data muxes.
- Honours fixed-length bursts, hlock, and SPLIT/RETRY responses; masks split masters until the slave asserts hsplit.
- Default master 0 is parked when no request is pending.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_rr_picker.sv | 37 +++
 rtl/ahb_arbiter.sv | 115 +++++++++++
 tb/tb_ahb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/response/burst encodings and arbiter state type shared by the arbiter slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR = 3'b001;
  localparam logic [2:0] HBURST_WRAP4 = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic [2:0] HBURST_WRAP8 = 3'b100;
  localparam logic [2:0] HBURST_INCR8 = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  typedef enum logic [1:0] {ARB_PARK, ARB_HANDOVER, ARB_OWN, ARB_BURST} arb_state_e;
  // Remaining SEQ beats after the NONSEQ beat; 0 means undefined-length or single.
  function automatic logic [3:0] burst_beats(input logic [2:0] b);
    return b[2:1] == 2'd1 ? 4'd3 : b[2:1] == 2'd2 ? 4'd7 : b[2:1] == 2'd3 ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: picks one eligible requester, round-robin after ptr or lowest index
// when AHB_ARB_FIXED_PRIORITY_EN is defined.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] elig,
  input  logic [1:0]   ptr,
  output logic [N-1:0] win,
  output logic [1:0]   idx,
  output logic         any
);
`ifdef AHB_ARB_FIXED_PRIORITY_EN
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) idx = 2'(i);
    any = |elig;
    win = '0;
    win[idx] = any;
  end
`else
  int k;
  // Scan backwards so the first hit in search order (ptr+1 upward) is written last.
  always_comb begin
    idx = '0;
    k = 0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(ptr) + i) % N;
      if (elig[k]) idx = 2'(k);
    end
    any = |elig;
    win = '0;
    win[idx] = any;
  end
`endif
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with fixed-length bursts, hlock and SPLIT/RETRY handling.
// Define AHB_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic                   hmastlock,
  output logic [NUM_MASTERS-1:0] split_mask
);
  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
  arb_state_e state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [1:0] ptr, ptr_d, gidx, gidx_d, hmaster_d, win_idx, nxt_idx;
  logic [NUM_MASTERS-1:0] hgrant_d, mask_set, mask_d, elig, win, nxt_oh;
  logic hmastlock_d, win_any, split_hit, retry_hit, park_go, rearb;
  assign split_hit = hresp == HRESP_SPLIT && !hready;
  assign retry_hit = hresp == HRESP_RETRY && !hready;
  assign mask_set = split_hit ? NUM_MASTERS'(1) << hmaster : '0;
  assign mask_d = (split_mask | mask_set) & ~hsplit;
  assign elig = hbusreq & ~(split_mask | mask_set);
  ahb_rr_picker #(.N(NUM_MASTERS)) u_pick (
    .elig(elig),
    .ptr(ptr),
    .win(win),
    .idx(win_idx),
    .any(win_any)
  );
  always_comb begin
    nxt_idx = win_any ? win_idx : DEF;
    nxt_oh = win_any ? win : DEF_OH;
    park_go = gidx == DEF && !hbusreq[gidx];
    rearb = 1'b0;
    state_d = state;
    cnt_d = cnt;
    ptr_d = ptr;
    gidx_d = gidx;
    hgrant_d = hgrant;
    hmaster_d = hmaster;
    hmastlock_d = hmastlock;
    case (state)
      ARB_PARK: if (win_any) begin
        gidx_d = win_idx;
        hgrant_d = win;
        state_d = ARB_HANDOVER;
      end
      ARB_HANDOVER: if (hready) begin
        hmaster_d = gidx;
        hmastlock_d = !park_go && hlock[gidx];
        ptr_d = gidx;
        state_d = park_go ? ARB_PARK : ARB_OWN;
      end
      ARB_OWN: if (split_hit) rearb = 1'b1;
      else if (hready) begin
        hmastlock_d = hlock[hmaster];
        if (htrans == HTRANS_NONSEQ && burst_beats(hburst) != 4'd0) begin
          cnt_d = burst_beats(hburst);
          state_d = ARB_BURST;
        end else rearb = !hmastlock && !hlock[hmaster];
      end
      default: if (split_hit) rearb = 1'b1;
      else if (retry_hit) state_d = ARB_OWN;
      else if (hready) begin
        hmastlock_d = hlock[hmaster];
        if (htrans == HTRANS_SEQ) begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_d = ARB_OWN;
            rearb = !hmastlock && !hlock[hmaster];
          end
        end else if (htrans != HTRANS_BUSY) state_d = ARB_OWN;
      end
    endcase
    // A split owner is already excluded from elig, so it can only win back by default parking.
    if (rearb) begin
      gidx_d = nxt_idx;
      hgrant_d = nxt_oh;
      state_d = nxt_idx != hmaster ? ARB_HANDOVER : win_any ? ARB_OWN : ARB_PARK;
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ARB_PARK;
      cnt <= '0;
      ptr <= DEF;
      gidx <= DEF;
      hgrant <= DEF_OH;
      hmaster <= DEF;
      hmastlock <= 1'b0;
      split_mask <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      ptr <= ptr_d;
      gidx <= gidx_d;
      hgrant <= hgrant_d;
      hmaster <= hmaster_d;
      hmastlock <= hmastlock_d;
      split_mask <= mask_d;
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scoreboard bench for ahb_arbiter grant, burst, lock, split and reset behaviour.
module tb_ahb_arbiter;
  import ahb_pkg::*;
`ifdef AHB_ARB_FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  typedef struct {
    string tag;
    logic [3:0] g;
    logic [1:0] m;
  } exp_t;
  logic hclk = 1'b0;
  logic hresetn = 1'b1;
  logic [3:0] hbusreq = '0, hlock = '0, hsplit = '0;
  logic [1:0] htrans = HTRANS_IDLE, hresp = HRESP_OKAY;
  logic [2:0] hburst = HBURST_SINGLE;
  logic hready = 1'b1;
  logic [3:0] hgrant, split_mask;
  logic [1:0] hmaster;
  logic hmastlock;
  int total = 0, bad = 0;
  exp_t sb[$];
  always #5 hclk = ~hclk;
  ahb_arbiter dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp), .hsplit(hsplit),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock), .split_mask(split_mask)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [3:0] g, input logic [1:0] m, input string tag);
    exp_t e;
    e.tag = tag;
    e.g = g;
    e.m = m;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".hgrant"}, 8'(hgrant), 8'(e.g));
    chk({e.tag, ".hmaster"}, 8'(hmaster), 8'(e.m));
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".hgrant"}, 8'(hgrant), 8'h01);
    chk({tag, ".hmaster"}, 8'(hmaster), 8'h0);
    chk({tag, ".hmastlock"}, 8'(hmastlock), 8'h0);
    chk({tag, ".split_mask"}, 8'(split_mask), 8'h0);
  endtask
  initial begin
    #2 hresetn = 1'b0;
    #1 chk_reset("reset");
    idle(2);
    hresetn = 1'b1;
    tick(4'b0001, 2'd0, "park0");
    tick(4'b0001, 2'd0, "park1");
    // Grant moves at once; hmaster waits for hready.
    hbusreq = 4'b0100;
    hready = 1'b0;
    tick(4'b0100, 2'd0, "ho_wait0");
    tick(4'b0100, 2'd0, "ho_wait1");
    hready = 1'b1;
    tick(4'b0100, 2'd2, "ho_done");
    // INCR4 with two BUSY beats inserted while master 1 waits.
    hbusreq = 4'b0110;
    htrans = HTRANS_NONSEQ;
    hburst = HBURST_INCR4;
    tick(4'b0100, 2'd2, "b4_nonseq");
    htrans = HTRANS_SEQ;
    tick(4'b0100, 2'd2, "b4_seq1");
    htrans = HTRANS_BUSY;
    tick(4'b0100, 2'd2, "b4_busy1");
    htrans = HTRANS_SEQ;
    tick(4'b0100, 2'd2, "b4_seq2");
    htrans = HTRANS_BUSY;
    tick(4'b0100, 2'd2, "b4_busy2");
    htrans = HTRANS_SEQ;
    tick(4'b0010, 2'd2, "b4_last");
    htrans = HTRANS_IDLE;
    tick(4'b0010, 2'd1, "b4_handover");
    // Masters 1 and 3 with single transfers.
    hbusreq = 4'b1010;
    htrans = HTRANS_NONSEQ;
    hburst = HBURST_SINGLE;
    tick(FP ? 4'b0010 : 4'b1000, 2'd1, "rr0");
    tick(FP ? 4'b0010 : 4'b1000, FP ? 2'd1 : 2'd3, "rr1");
    tick(4'b0010, FP ? 2'd1 : 2'd3, "rr2");
    tick(4'b0010, 2'd1, "rr3");
    tick(FP ? 4'b0010 : 4'b1000, 2'd1, "rr4");
    tick(FP ? 4'b0010 : 4'b1000, FP ? 2'd1 : 2'd3, "rr5");
    // Locked master 1 holds the bus against master 3.
    hbusreq = 4'b0010;
    hlock = 4'b0010;
    tick(4'b0010, FP ? 2'd1 : 2'd3, "lk_acq");
    tick(4'b0010, 2'd1, "lk_own");
    chk("lk_own.hmastlock", 8'(hmastlock), 8'h1);
    hbusreq = 4'b1010;
    for (int i = 0; i < 3; i++) tick(4'b0010, 2'd1, "lk_hold");
    chk("lk_hold.hmastlock", 8'(hmastlock), 8'h1);
    hlock = 4'b0000;
    tick(4'b0010, 2'd1, "lk_drop");
    chk("lk_drop.hmastlock", 8'(hmastlock), 8'h0);
    tick(FP ? 4'b0010 : 4'b1000, 2'd1, "lk_release");
    // Master 2 takes the bus, then gets SPLIT.
    hbusreq = 4'b0100;
    idle(2);
    tick(4'b0100, 2'd2, "sp_own");
    hbusreq = 4'b1110;
    hready = 1'b0;
    hresp = HRESP_SPLIT;
    tick(FP ? 4'b0010 : 4'b1000, 2'd2, "sp_resp1");
    chk("sp_resp1.split_mask", 8'(split_mask), 8'h04);
    hready = 1'b1;
    htrans = HTRANS_IDLE;
    tick(FP ? 4'b0010 : 4'b1000, FP ? 2'd1 : 2'd3, "sp_resp2");
    hresp = HRESP_OKAY;
    tick(4'b0010, FP ? 2'd1 : 2'd3, "sp_masked");
    chk("sp_masked.split_mask", 8'(split_mask), 8'h04);
    hsplit = 4'b0100;
    tick(4'b0010, 2'd1, "sp_resume");
    chk("sp_resume.split_mask", 8'(split_mask), 8'h00);
    hsplit = 4'b0000;
    tick(FP ? 4'b0010 : 4'b0100, 2'd1, "sp_regain");
    // Reset in the middle of an INCR8 at beat 5.
    hbusreq = 4'b0100;
    idle(2);
    tick(4'b0100, 2'd2, "b8_own");
    htrans = HTRANS_NONSEQ;
    hburst = HBURST_INCR8;
    tick(4'b0100, 2'd2, "b8_beat1");
    htrans = HTRANS_SEQ;
    for (int i = 2; i <= 5; i++) tick(4'b0100, 2'd2, $sformatf("b8_beat%0d", i));
    #3 hresetn = 1'b0;
    #1 chk_reset("mid_reset");
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    hbusreq = 4'b0000;
    htrans = HTRANS_IDLE;
    hburst = HBURST_SINGLE;
    tick(4'b0001, 2'd0, "post_park0");
    tick(4'b0001, 2'd0, "post_park1");
    hbusreq = 4'b1000;
    tick(4'b1000, 2'd0, "post_req");
    tick(4'b1000, 2'd3, "post_own");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end
endmodule
